regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file with a per-register busy scoreboard, used as the next-generation architectural register file of the core pipeline. It provides NRD combinational read ports, one synchronous write port, hard-wired zero for register 0, and busy tracking so decode can stall on registers with an outstanding writeback. An optional write-to-read bypass removes the one-cycle write-then-read bubble.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, minimum 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREG), address width; derived, not overridden

- iClk  in  1  clock, rising edge active
- iRstN  in  1  reset, asynchronous, active-low
- iWriteEn  in  1  write strobe for the writeback port
- iRdAddr  in  AW  write address
- iWriteData  in  XLEN  write data
- iIssueEn  in  1  marks iIssueRd as having a pending writeback
- iIssueRd  in  AW  destination register of the issuing instruction
- iReadEn  in  NRD  per-port read enable
- iRsAddr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- oRsData  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
- oRsBusy  out  NRD  port k's register has a pending writeback
- oBusyVec  out  NREG  raw scoreboard; bit 0 always 0

## Operation
- Reset: all registers 0 and all busy bits 0, asynchronously. oRsData, oRsBusy and oBusyVec read 0 while iRstN is low.
- Write: on a rising edge with iWriteEn=1 and iRdAddr!=0, the register takes iWriteData. Writes to address 0 are dropped.
- Read port k:
  - iReadEn[k]=0: data 0 and busy 0.
  - Address 0: data 0 and busy 0.
  - Otherwise: register contents and busy bit, subject to the bypass rule under Configuration.
- Scoreboard, per register r!=0, updated on each rising edge:
  - Set when iIssueEn=1 and iIssueRd==r.
  - Cleared when iWriteEn=1 and iRdAddr==r.
  - Set and clear in the same cycle on the same r: set wins (a new producer supersedes the old one).
  - Issue or write to address 0 never changes any state.
- Write to a register that is not busy: data is written and the busy bit stays 0. This is legal.
- Repeated issue to a busy register: the bit stays 1.
- Multiple read ports may address the same register at once; every port returns identical results.

## Timing
- Reads are combinational, with zero cycles of latency from iRsAddr or iReadEn to the outputs.
- Write data becomes visible on the read path:
  - Bypass in: in the same cycle as the write.
  - Bypass out: in the cycle after the write edge.
- A busy bit set by issue on edge N is visible after edge N.
- Reset asserted mid-operation clears all state immediately. The first write is accepted on the first rising edge after deassertion.

## Configuration
- REGFILE_BYPASS_EN defined: when iWriteEn=1 and iRdAddr equals a nonzero enabled read address, that port returns iWriteData.
  - oRsBusy for that port is 0, unless iIssueEn=1 with iIssueRd at the same address in the same cycle; then it is 1.
  - Data is still forwarded in that case.
- REGFILE_BYPASS_EN undefined: reads return only the stored value, and oRsBusy reflects only the registered scoreboard. A same-cycle read sees old data and old busy state.

## Test plan
- Reset, then read all addresses on all ports with iReadEn all ones -> every oRsData=0 and oBusyVec=0.
- Write 0xDEADBEEF to x5, then read x5 on port 0 and port 1 in the next cycle -> both ports return 0xDEADBEEF and busy 0.
- Write 0x12345678 to x0 -> reading x0 returns 0; oBusyVec[0] stays 0 after iIssueEn with iIssueRd=0.
- Issue x7 -> oBusyVec[7]=1. A later write to x7 with 0xA5A5A5A5 -> busy 0 and data 0xA5A5A5A5 after the edge.
  - Same-cycle issue and write on x7 -> busy stays 1.
- Same-cycle write of 0x0000CAFE to x3 while port 0 reads x3:
  - REGFILE_BYPASS_EN defined -> 0x0000CAFE in that cycle.
  - Undefined -> prior value, then 0x0000CAFE in the next cycle.
- Assert iRstN low mid-sequence with x9 holding 0x55 and busy -> data 0 and busy 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and hard-wired zero at x0.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iWriteEn,
  input  logic [AW-1:0]       iRdAddr,
  input  logic [XLEN-1:0]     iWriteData,
  input  logic                iIssueEn,
  input  logic [AW-1:0]       iIssueRd,
  input  logic [NRD-1:0]      iReadEn,
  input  logic [NRD*AW-1:0]   iRsAddr,
  output logic [NRD*XLEN-1:0] oRsData,
  output logic [NRD-1:0]      oRsBusy,
  output logic [NREG-1:0]     oBusyVec
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            wr_valid;
  logic            iss_valid;

  // Anything aimed at x0 is discarded before it reaches state.
  assign wr_valid  = iWriteEn && (iRdAddr != '0);
  assign iss_valid = iIssueEn && (iIssueRd != '0);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_reg[iRdAddr] <= iWriteData;
    end
  end

  // Clear first, then set, so a new producer supersedes a completing one.
  always_comb begin
    busy_next = busy_reg;
    if (wr_valid) begin
      busy_next[iRdAddr] = 1'b0;
    end
    if (iss_valid) begin
      busy_next[iIssueRd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign oBusyVec = iRstN ? busy_reg : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic            rd_hit;
      logic [XLEN-1:0] rd_data;
      logic            rd_busy;

      assign rd_addr = iRsAddr[gi*AW +: AW];
      assign rd_hit  = iRstN && iReadEn[gi] && (rd_addr != '0);

`ifdef REGFILE_BYPASS_EN
      logic byp_hit;
      assign byp_hit = wr_valid && (iRdAddr == rd_addr);

      // Forwarded data is final; only a same-cycle reissue keeps it busy.
      always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rd_hit) begin
          if (byp_hit) begin
            rd_data = iWriteData;
            rd_busy = iss_valid && (iIssueRd == rd_addr);
          end else begin
            rd_data = regs_reg[rd_addr];
            rd_busy = busy_reg[rd_addr];
          end
        end
      end
`else
      always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rd_hit) begin
          rd_data = regs_reg[rd_addr];
          rd_busy = busy_reg[rd_addr];
        end
      end
`endif

      assign oRsData[gi*XLEN +: XLEN] = rd_data;
      assign oRsBusy[gi]              = rd_busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32x32, two read ports).
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                write_en;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     write_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic [NRD-1:0]      read_en;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NREG-1:0]     busy_vec;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iWriteEn  (write_en),
    .iRdAddr   (rd_addr),
    .iWriteData(write_data),
    .iIssueEn  (issue_en),
    .iIssueRd  (issue_rd),
    .iReadEn   (read_en),
    .iRsAddr   (rs_addr),
    .oRsData   (rs_data),
    .oRsBusy   (rs_busy),
    .oBusyVec  (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic chk_port(input string tag, input int p, input logic [31:0] d, input logic b);
    chk({tag, "_data"}, rs_data[p*XLEN +: XLEN], d);
    chk({tag, "_busy"}, {31'd0, rs_busy[p]}, {31'd0, b});
  endtask

  initial begin
    rst_n = 1'b0; write_en = 1'b0; rd_addr = '0; write_data = '0;
    issue_en = 1'b0; issue_rd = '0; read_en = 2'b11; set_rd(5, 7);
    #2;
    chk("rst_busyvec", busy_vec, 32'h0);
    chk_port("rst_p0", 0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Every address on both ports reads zero after reset.
    for (int a = 0; a < NREG; a++) begin
      set_rd(a[AW-1:0], 5'(31 - a));
      #1;
      chk("init_p0", rs_data[31:0], 32'h0);
      chk("init_p1", rs_data[63:32], 32'h0);
      chk("init_busy", {30'd0, rs_busy}, 32'h0);
    end
    chk("init_busyvec", busy_vec, 32'h0);
    $display("step: reset read sweep done");

    write_en = 1'b1; rd_addr = 5; write_data = 32'hDEADBEEF;
    tick();
    write_en = 1'b0; set_rd(5, 5);
    #1;
    chk_port("x5_p0", 0, 32'hDEADBEEF, 1'b0);
    chk_port("x5_p1", 1, 32'hDEADBEEF, 1'b0);
    $display("step: write x5 then read on both ports");

    read_en = 2'b10;
    #1;
    chk_port("x5_en0", 0, 32'h0, 1'b0);
    chk_port("x5_en1", 1, 32'hDEADBEEF, 1'b0);
    read_en = 2'b11;
    $display("step: read enable gating");

    write_en = 1'b1; rd_addr = 0; write_data = 32'h12345678;
    tick();
    write_en = 1'b0; set_rd(0, 0);
    #1;
    chk_port("x0_p0", 0, 32'h0, 1'b0);
    chk_port("x0_p1", 1, 32'h0, 1'b0);
    issue_en = 1'b1; issue_rd = 0;
    tick();
    issue_en = 1'b0;
    #1;
    chk("x0_issue_busyvec", busy_vec, 32'h0);
    $display("step: write and issue to x0 ignored");

    issue_en = 1'b1; issue_rd = 7;
    tick();
    issue_en = 1'b0; set_rd(7, 5);
    #1;
    chk("iss7_busyvec", busy_vec, 32'h0000_0080);
    chk_port("iss7_p0", 0, 32'h0, 1'b1);
    chk_port("iss7_p1", 1, 32'hDEADBEEF, 1'b0);
    issue_en = 1'b1;
    tick();
    issue_en = 1'b0;
    #1;
    chk("reiss7_busyvec", busy_vec, 32'h0000_0080);
    $display("step: issue x7, reissue keeps busy");

    // Issue and write on x7 together: the new producer wins.
    issue_en = 1'b1; issue_rd = 7; write_en = 1'b1; rd_addr = 7; write_data = 32'h11111111;
    #1;
    chk_port("iw7_same", 0, BYP ? 32'h11111111 : 32'h0, 1'b1);
    tick();
    issue_en = 1'b0; write_en = 1'b0;
    #1;
    chk("iw7_busyvec", busy_vec, 32'h0000_0080);
    chk_port("iw7_after", 0, 32'h11111111, 1'b1);
    $display("step: same-cycle issue and write x7");

    write_en = 1'b1; rd_addr = 7; write_data = 32'hA5A5A5A5;
    #1;
    chk_port("w7_same", 0, BYP ? 32'hA5A5A5A5 : 32'h11111111, BYP ? 1'b0 : 1'b1);
    tick();
    write_en = 1'b0;
    #1;
    chk("w7_busyvec", busy_vec, 32'h0);
    chk_port("w7_after", 0, 32'hA5A5A5A5, 1'b0);
    $display("step: writeback x7 clears busy");

    set_rd(3, 3);
    write_en = 1'b1; rd_addr = 3; write_data = 32'h0000CAFE;
    #1;
    chk_port("byp3_p0", 0, BYP ? 32'h0000CAFE : 32'h0, 1'b0);
    chk_port("byp3_p1", 1, BYP ? 32'h0000CAFE : 32'h0, 1'b0);
    tick();
    write_en = 1'b0;
    #1;
    chk_port("w3_after", 0, 32'h0000CAFE, 1'b0);
    $display("step: same-cycle write/read x3");

    write_en = 1'b1; rd_addr = 9; write_data = 32'h55; issue_en = 1'b1; issue_rd = 9;
    tick();
    write_en = 1'b0; issue_en = 1'b0; set_rd(9, 3);
    #1;
    chk("x9_busyvec", busy_vec, 32'h0000_0200);
    chk_port("x9_pre", 0, 32'h55, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busyvec", busy_vec, 32'h0);
    chk_port("mrst_p0", 0, 32'h0, 1'b0);
    chk_port("mrst_p1", 1, 32'h0, 1'b0);
    write_en = 1'b1; rd_addr = 3; write_data = 32'hFFFF0000;
    #1;
    chk_port("mrst_wr_gated", 1, 32'h0, 1'b0);
    write_en = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    #1;
    chk_port("post_rst_x9", 0, 32'h0, 1'b0);
    chk_port("post_rst_x3", 1, 32'h0, 1'b0);
    write_en = 1'b1; rd_addr = 9; write_data = 32'h77;
    tick();
    write_en = 1'b0;
    #1;
    chk_port("first_wr_x9", 0, 32'h77, 1'b0);
    $display("step: async reset mid-sequence and first write after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
